// File: rtl/tug_playfield.sv
// tug_playfield -- tug-of-war playfield driver.
//
// Conditions the two player buttons into single-cycle presses, walks a lit
// LED along LEDR[9:1] toward the pressing player, scores round wins on the
// end LEDs and stops the game once a player reaches SCORE_MAX wins.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   L, R       player buttons, active-high, asynchronous to clk
//   LEDR[9:0]  playfield, one-hot over bits 9..1 during play, bit 0 always 0
//   HEX5[6:0]  left score digit, active-low {g,f,e,d,c,b,a}
//   HEX0[6:0]  right score digit, same encoding
//   round_over high while a round-win state is held
//   game_over  high once either score reaches SCORE_MAX
module tug_playfield #(
  parameter int unsigned SCORE_MAX = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  output logic [9:0] LEDR,
  output logic [6:0] HEX5,
  output logic [6:0] HEX0,
  output logic       round_over,
  output logic       game_over
);

  localparam logic [3:0] SMAX   = 4'(SCORE_MAX);
  localparam logic [3:0] CENTRE = 4'd5;

  // Three-bit encoding leaves spare codes; any of them falls back to PLAY.
  typedef enum logic [2:0] {
    PLAY      = 3'd0,
    WIN_L     = 3'd1,
    WIN_R     = 3'd2,
    GAME_OVER = 3'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] pos_q, pos_d;
  logic [3:0] lscore_q, lscore_d;
  logic [3:0] rscore_q, rscore_d;

  logic l_s1, l_s2, l_prev;
  logic r_s1, r_s2, r_prev;
  logic l_press, r_press;
  logic l_only, r_only;

  logic [9:0] ledr_q, ledr_d;
  logic [6:0] hex5_q, hex5_d;
  logic [6:0] hex0_q, hex0_d;
  logic       ro_q, ro_d;
  logic       go_q, go_d;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Two-flop synchronizers plus a previous-value flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      l_s1   <= 1'b0;
      l_s2   <= 1'b0;
      l_prev <= 1'b0;
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      l_s1   <= L;
      l_s2   <= l_s1;
      l_prev <= l_s2;
      r_s1   <= R;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign l_press = l_s2 & ~l_prev;
  assign r_press = r_s2 & ~r_prev;
  // Simultaneous presses cancel out in every state.
  assign l_only  = l_press & ~r_press;
  assign r_only  = r_press & ~l_press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= PLAY;
      pos_q    <= CENTRE;
      lscore_q <= '0;
      rscore_q <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      lscore_q <= lscore_d;
      rscore_q <= rscore_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    lscore_d = lscore_q;
    rscore_d = rscore_q;
    case (state_q)
      PLAY: begin
        if (pos_q < 4'd1 || pos_q > 4'd9) begin
          pos_d = CENTRE;
        end else if (l_only) begin
          if (pos_q != 4'd9) begin
            pos_d = pos_q + 4'd1;
          end else if (lscore_q < SMAX) begin
            lscore_d = lscore_q + 4'd1;
            state_d  = (lscore_d == SMAX) ? GAME_OVER : WIN_L;
          end
        end else if (r_only) begin
          if (pos_q != 4'd1) begin
            pos_d = pos_q - 4'd1;
          end else if (rscore_q < SMAX) begin
            rscore_d = rscore_q + 4'd1;
            state_d  = (rscore_d == SMAX) ? GAME_OVER : WIN_R;
          end
        end
      end
      WIN_L, WIN_R: begin
        if (l_only || r_only) begin
          state_d = PLAY;
          pos_d   = CENTRE;
        end
      end
      GAME_OVER: begin
        state_d = GAME_OVER;
      end
      default: begin
        state_d = PLAY;
        pos_d   = CENTRE;
      end
    endcase
  end

  // Outputs are decoded from the next-state values and registered, so they
  // change on the same edge as the state and never glitch.
  always_comb begin
    ledr_d = '0;
    if (state_d == PLAY) begin
      ledr_d    = 10'd1 << pos_d;
      ledr_d[0] = 1'b0;
    end
    ro_d   = (state_d == WIN_L) || (state_d == WIN_R);
    go_d   = (state_d == GAME_OVER);
    hex5_d = seg7(lscore_d);
    hex0_d = seg7(rscore_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ledr_q <= 10'b0000100000;
      hex5_q <= 7'b1000000;
      hex0_q <= 7'b1000000;
      ro_q   <= 1'b0;
      go_q   <= 1'b0;
    end else begin
      ledr_q <= ledr_d;
      hex5_q <= hex5_d;
      hex0_q <= hex0_d;
      ro_q   <= ro_d;
      go_q   <= go_d;
    end
  end

  assign LEDR       = ledr_q;
  assign HEX5       = hex5_q;
  assign HEX0       = hex0_q;
  assign round_over = ro_q;
  assign game_over  = go_q;

endmodule

// File: tb/tb_tug_playfield.sv
// Self-checking bench for tug_playfield: constant vector table, hand-written
// multi-cycle sequences and a randomized run against a game-level model.
module tb_tug_playfield;

  localparam int SMAX = 7;

  logic       clk;
  logic       reset;
  logic       L, R;
  logic [9:0] LEDR;
  logic [6:0] HEX5, HEX0;
  logic       round_over, game_over;

  tug_playfield #(.SCORE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset), .L(L), .R(R),
    .LEDR(LEDR), .HEX5(HEX5), .HEX0(HEX0),
    .round_over(round_over), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Game-level reference model.
  int   m_pos, m_ls, m_rs, m_mode;  // mode 0 play, 1 round won, 2 game over
  logic lh[3];                      // L samples at edges n-1, n-2, n-3
  logic rh[3];
  logic [6:0] seg_tab[10];

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg(input int v);
    if (v >= 0 && v <= 9) return seg_tab[v];
    return 7'b1111111;
  endfunction

  task automatic model_reset();
    m_pos = 5; m_ls = 0; m_rs = 0; m_mode = 0;
    for (int i = 0; i < 3; i++) begin lh[i] = 1'b0; rh[i] = 1'b0; end
  endtask

  // Called right after each active edge with the values L/R had at that edge.
  task automatic model_step();
    logic pl, pr;
    pl = lh[1] & ~lh[2];
    pr = rh[1] & ~rh[2];
    lh[2] = lh[1]; lh[1] = lh[0]; lh[0] = L;
    rh[2] = rh[1]; rh[1] = rh[0]; rh[0] = R;
    if (pl != pr && m_mode != 2) begin
      if (m_mode == 1) begin
        m_mode = 0; m_pos = 5;
      end else if (pl) begin
        if (m_pos < 9) m_pos++;
        else begin m_ls++; m_mode = (m_ls == SMAX) ? 2 : 1; end
      end else begin
        if (m_pos > 1) m_pos--;
        else begin m_rs++; m_mode = (m_rs == SMAX) ? 2 : 1; end
      end
    end
  endtask

  task automatic cmp_model();
    logic [9:0] eled;
    eled = (m_mode == 0) ? (10'd1 << m_pos) : 10'd0;
    chk("model_ledr", {6'd0, LEDR}, {6'd0, eled});
    chk("model_hex5", {9'd0, HEX5}, {9'd0, seg(m_ls)});
    chk("model_hex0", {9'd0, HEX0}, {9'd0, seg(m_rs)});
    chk("model_round_over", {15'd0, round_over}, {15'd0, (m_mode == 1)});
    chk("model_game_over", {15'd0, game_over}, {15'd0, (m_mode == 2)});
  endtask

  task automatic step(input logic l, input logic r);
    @(negedge clk);
    L = l; R = r;
    @(posedge clk);
    model_step();
    #1 cmp_model();
  endtask

  task automatic pulse(input logic l, input logic r);
    step(l, r);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; L = 1'b0; R = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 cmp_model();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_outs(input string nm, input logic [9:0] eled, input logic [6:0] e5,
                          input logic [6:0] e0, input logic ero, input logic ego);
    chk({nm, "_ledr"}, {6'd0, LEDR}, {6'd0, eled});
    chk({nm, "_hex5"}, {9'd0, HEX5}, {9'd0, e5});
    chk({nm, "_hex0"}, {9'd0, HEX0}, {9'd0, e0});
    chk({nm, "_round_over"}, {15'd0, round_over}, {15'd0, ero});
    chk({nm, "_game_over"}, {15'd0, game_over}, {15'd0, ego});
  endtask

  typedef struct {
    logic       l;
    logic       r;
    logic [9:0] ledr;
    logic [6:0] h5;
    logic [6:0] h0;
    logic       ro;
    logic       go;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic nl, nr;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Each entry: drive l/r for 3 cycles, then expect these outputs.
    vecs[0]  = '{1'b0, 1'b0, 10'h020, 7'h40, 7'h40, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 10'h040, 7'h40, 7'h40, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 10'h040, 7'h40, 7'h40, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 10'h040, 7'h40, 7'h40, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 10'h080, 7'h40, 7'h40, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 10'h080, 7'h40, 7'h40, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 10'h100, 7'h40, 7'h40, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 10'h100, 7'h40, 7'h40, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 10'h200, 7'h40, 7'h40, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 10'h200, 7'h40, 7'h40, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 10'h000, 7'h79, 7'h40, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 10'h000, 7'h79, 7'h40, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 10'h020, 7'h79, 7'h40, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 10'h020, 7'h79, 7'h40, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 10'h020, 7'h79, 7'h40, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 10'h020, 7'h79, 7'h40, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 10'h010, 7'h79, 7'h40, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 10'h010, 7'h79, 7'h40, 1'b0, 1'b0};

    reset = 1'b1; L = 1'b0; R = 1'b0;
    model_reset();
    #1 chk_outs("reset", 10'h020, 7'h40, 7'h40, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
    chk_outs("idle", 10'h020, 7'h40, 7'h40, 1'b0, 1'b0);

    // Table-driven sequence.
    for (int i = 0; i < 18; i++) begin
      for (int c = 0; c < 3; c++) step(vecs[i].l, vecs[i].r);
      chk_outs($sformatf("vec%0d", i), vecs[i].ledr, vecs[i].h5, vecs[i].h0, vecs[i].ro, vecs[i].go);
    end

    // Long hold: exactly one move, at the second edge after L is first seen.
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("hold_before", {6'd0, LEDR}, 16'h0020);
    step(1'b1, 1'b0);
    chk("hold_move", {6'd0, LEDR}, 16'h0040);
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    chk("hold_single", {6'd0, LEDR}, 16'h0040);

    // Simultaneous presses from centre.
    do_reset();
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b1);
    chk_outs("simul", 10'h020, 7'h40, 7'h40, 1'b0, 1'b0);

    // Right player wins SMAX rounds.
    do_reset();
    for (int rd = 0; rd < SMAX; rd++) begin
      for (int p = 0; p < 5; p++) pulse(1'b0, 1'b1);
      if (rd < SMAX - 1) pulse(1'b0, 1'b1);
    end
    chk_outs("rwin", 10'h000, 7'h40, 7'h78, 1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    chk_outs("gover_hold", 10'h000, 7'h40, 7'h78, 1'b0, 1'b1);

    // Asynchronous reset mid-round, left score 3, pos 7.
    do_reset();
    for (int rd = 0; rd < 3; rd++) begin
      for (int p = 0; p < 5; p++) pulse(1'b1, 1'b0);
      pulse(1'b0, 1'b1);
    end
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b0);
    chk_outs("pre_areset", 10'h080, 7'h30, 7'h40, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 chk_outs("areset", 10'h020, 7'h40, 7'h40, 1'b0, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Randomized play against the model, with occasional resets.
    nl = 1'b0; nr = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
        nl = 1'b0; nr = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) nl = ~nl;
        if ($urandom_range(0, 4) == 0) nr = ~nr;
        step(nl, nr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tug_playfield.md
Name: tug_playfield

Overview:
- Playfield driver for the tug-of-war game: converts raw left/right player buttons into single-cycle presses and moves the lit LED along LEDR[9:1] one step toward the pressing player.
- When a player presses while the light is already at their end LED, the block declares a round win, keeps score on the seven-segment displays and ends the game at SCORE_MAX.
- Sits between the board buttons (L, R) and the LED/HEX outputs at the top level.

Parameters:
SCORE_MAX, 7, wins required to end the game; legal range 1..9.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
L  input  1  left player button, active-high, asynchronous to clk
R  input  1  right player button, active-high, asynchronous to clk
LEDR  output  10  playfield; one-hot over bits 9..1 during play; bit 0 is always 0
HEX5  output  7  left score digit, active-low segments {g,f,e,d,c,b,a}
HEX0  output  7  right score digit, same encoding
round_over  output  1  high while a round-win state is held
game_over  output  1  high once either score reaches SCORE_MAX

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-round or mid-sync. Reset values:
  - state PLAY, pos=5, both scores 0, all synchronizer and edge flops 0.
  - LEDR=10'b0000100000, HEX5=HEX0=7'b1000000, round_over=0, game_over=0.
- Input conditioning:
  - Each of L and R passes through a 2-flop synchronizer, then a rising-edge detector (sync2 & ~prev).
  - The detector yields l_press / r_press, each one cycle wide.
  - A button held for any number of cycles produces exactly one press.
- Latency: if L is high at rising edge k, l_press is high in the cycle after edge k+1, and pos/state update at edge k+2.
- Simultaneous presses (l_press & r_press in the same cycle) are ignored in every state.
- Position register pos ranges 1..9. LEDR[pos]=1 in PLAY; all other bits 0.
- State PLAY:
  - l_press only, pos<9: pos<=pos+1.
  - l_press only, pos==9: left score +1, pos held. If the new left score == SCORE_MAX go to GAME_OVER, else go to WIN_L.
  - r_press only, pos>1: pos<=pos-1.
  - r_press only, pos==1: right score +1. If the new right score == SCORE_MAX go to GAME_OVER, else go to WIN_R.
  - no press: hold.
- States WIN_L / WIN_R:
  - LEDR=0, round_over=1.
  - The next single press (either button) returns to PLAY with pos=5, and round_over drops on that edge.
- State GAME_OVER:
  - LEDR=0, round_over=0, game_over=1.
  - All presses are ignored; only reset leaves this state.
- Scores:
  - 4-bit counters that increment only on win transitions and never exceed SCORE_MAX.
  - Both scores are displayed continuously in every state.
- Seven-segment encoding, registered or combinational from the score register (no added latency beyond the score update):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any other value = 1111111.
- All outputs are glitch-free functions of registered state.
- Unreachable state encodings recover to PLAY with pos=5.

Test Plan:
- Reset then idle 10 cycles -> LEDR=10'b0000100000, HEX5=HEX0=7'b1000000, round_over=0, game_over=0.
- Hold L high 20 cycles, then release -> exactly one move: LEDR=10'b0001000000 at edge k+2, with no further change.
- Four separate L pulses, then one more L pulse -> LEDR reaches bit 9; the fifth press gives LEDR=0, round_over=1, HEX5=7'b1111001; next R press gives LEDR=10'b0000100000, round_over=0.
- L and R both rising in the same cycle, repeated 5 times from centre -> LEDR stays 10'b0000100000 and scores are unchanged.
- Right player wins 7 rounds (4 R pulses + 1 R per round, plus a restart press between rounds) with SCORE_MAX=7 -> HEX0=7'b1111000, game_over=1; further L/R presses produce no change.
- Assert reset asynchronously mid-round with pos=7 and left score 3 (between clock edges) -> outputs return to reset values before the next clk edge.
